// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI bus arbiter: FSM states,
// grant owner, default opcodes and per-phase nibble counts.
package qspi_pkg;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;
    typedef enum logic {FETCH, MEM} grant_t;

    localparam logic [7:0] OP_FLASH_READ = 8'hEB;
    localparam logic [7:0] OP_RAM_READ   = 8'hEB;
    localparam logic [7:0] OP_RAM_WRITE  = 8'h38;

    localparam int CMD_NIBBLES  = 2;
    localparam int ADDR_NIBBLES = 6;
    localparam int DATA_NIBBLES = 2;

    // Chip select is low and the SPI clock runs only in these states.
    function automatic logic is_busy(input state_t s);
        return (s == CMD) || (s == ADDR) || (s == DUMMY) || (s == DATA);
    endfunction

endpackage

// File: rtl/qspi_nibble_shifter.sv
// Nibble-serial datapath: 32-bit MSB-first transmit register, 8-bit receive
// register and the two-cycle phase toggle that forms the SPI clock.
module qspi_nibble_shifter (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        shift_in_en,
    input  logic [3:0]  data_in,
    output logic        phase,
    output logic        strobe,
    output logic [3:0]  tx_nibble,
    output logic [7:0]  rx_next
);

    logic        phase_reg;
    logic [31:0] tx_reg;
    logic [7:0]  rx_reg;

    // strobe marks the clock edge that closes phase 1, i.e. the end of a nibble.
    assign phase     = phase_reg;
    assign strobe    = run & phase_reg;
    assign tx_nibble = tx_reg[31:28];
    assign rx_next   = {rx_reg[3:0], data_in};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_reg <= 1'b0;
            tx_reg    <= '0;
            rx_reg    <= '0;
        end else begin
            phase_reg <= run ? ~phase_reg : 1'b0;
            if (load) begin
                tx_reg <= load_value;
            end else if (strobe) begin
                tx_reg <= {tx_reg[27:0], 4'h0};
            end
            if (strobe && shift_in_en) begin
                rx_reg <= rx_next;
            end
        end
    end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Round-robin owner of the shared QPI bus: serves one byte transaction per
// grant for the instruction-fetch port (flash) and the data port (RAM A).
module qspi_bus_arbiter
    import qspi_pkg::*;
#(
    parameter int         ADDRESS_WIDTH  = 16,
    parameter int         DATA_BUS_WIDTH = 8,
    parameter int         FLASH_DUMMY    = 4,
    parameter int         RAM_DUMMY      = 6,
    parameter logic [7:0] CMD_FLASH_READ = OP_FLASH_READ,
    parameter logic [7:0] CMD_RAM_READ   = OP_RAM_READ,
    parameter logic [7:0] CMD_RAM_WRITE  = OP_RAM_WRITE
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fetch_req,
    input  logic [ADDRESS_WIDTH-1:0]  fetch_addr,
    output logic [DATA_BUS_WIDTH-1:0] fetch_data,
    output logic                      fetch_ack,
    input  logic                      mem_req,
    input  logic                      mem_we,
    input  logic [ADDRESS_WIDTH-1:0]  mem_addr,
    input  logic [DATA_BUS_WIDTH-1:0] mem_wdata,
    output logic [DATA_BUS_WIDTH-1:0] mem_rdata,
    output logic                      mem_ack,
    input  logic [3:0]                spi_data_in,
    output logic [3:0]                spi_data_out,
    output logic [3:0]                spi_data_oe,
    output logic                      spi_clk_out,
    output logic                      spi_flash_select,
    output logic                      spi_ram_a_select
);

    state_t                    state_reg, state_next;
    grant_t                    last_grant_reg, last_grant_next, pick;
    logic [7:0]                cnt_reg, cnt_next, nibble_limit;
    logic                      we_reg, we_next;
    logic [DATA_BUS_WIDTH-1:0] wdata_reg, wdata_next;
    logic [DATA_BUS_WIDTH-1:0] fetch_data_reg, fetch_data_next;
    logic [DATA_BUS_WIDTH-1:0] mem_rdata_reg, mem_rdata_next;
    logic                      last_nibble, load, busy, phase, strobe;
    logic [31:0]               load_value;
    logic [3:0]                tx_nibble;
    logic [7:0]                rx_next;

    qspi_nibble_shifter u_shifter (
        .clock       (clock),
        .reset       (reset),
        .run         (busy),
        .load        (load),
        .load_value  (load_value),
        .shift_in_en ((state_reg == DATA) && !we_reg),
        .data_in     (spi_data_in),
        .phase       (phase),
        .strobe      (strobe),
        .tx_nibble   (tx_nibble),
        .rx_next     (rx_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= MEM;
            cnt_reg        <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            fetch_data_reg <= '0;
            mem_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            we_reg         <= we_next;
            wdata_reg      <= wdata_next;
            fetch_data_reg <= fetch_data_next;
            mem_rdata_reg  <= mem_rdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        we_next         = we_reg;
        wdata_next      = wdata_reg;
        fetch_data_next = fetch_data_reg;
        mem_rdata_next  = mem_rdata_reg;
        load            = 1'b0;
        load_value      = '0;
        pick            = FETCH;
        nibble_limit    = 8'd1;

        case (state_reg)
            CMD:     nibble_limit = 8'(CMD_NIBBLES);
            ADDR:    nibble_limit = 8'(ADDR_NIBBLES);
            DUMMY:   nibble_limit = (last_grant_reg == FETCH) ? 8'(FLASH_DUMMY) : 8'(RAM_DUMMY);
            DATA:    nibble_limit = 8'(DATA_NIBBLES);
            default: nibble_limit = 8'd1;
        endcase
        last_nibble = strobe && (cnt_reg == nibble_limit - 8'd1);
        if (strobe) begin
            cnt_next = last_nibble ? 8'd0 : cnt_reg + 8'd1;
        end

        case (state_reg)
            IDLE: begin
                if (fetch_req || mem_req) begin
                    // last_grant doubles as the owner of the transaction in flight.
                    if (fetch_req && mem_req) begin
                        pick = (last_grant_reg == FETCH) ? MEM : FETCH;
                    end else begin
                        pick = fetch_req ? FETCH : MEM;
                    end
                    last_grant_next = pick;
                    we_next         = (pick == MEM) && mem_we;
                    wdata_next      = mem_wdata;
                    load            = 1'b1;
                    if (pick == FETCH) begin
                        load_value = {CMD_FLASH_READ, 24'(fetch_addr)};
                    end else begin
                        load_value = {(mem_we ? CMD_RAM_WRITE : CMD_RAM_READ), 24'(mem_addr)};
                    end
                    cnt_next   = 8'd0;
                    state_next = CMD;
                end
            end
            CMD: begin
                if (last_nibble) state_next = ADDR;
            end
            ADDR: begin
                if (last_nibble) begin
                    if (we_reg) begin
                        // Writes go straight to data; reload the shifter with the byte.
                        state_next = DATA;
                        load       = 1'b1;
                        load_value = {wdata_reg, 24'h0};
                    end else begin
                        state_next = DUMMY;
                    end
                end
            end
            DUMMY: begin
                if (last_nibble) state_next = DATA;
            end
            DATA: begin
                if (last_nibble) begin
                    state_next = DONE;
                    if (!we_reg) begin
                        if (last_grant_reg == FETCH) fetch_data_next = rx_next;
                        else                         mem_rdata_next  = rx_next;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy             = is_busy(state_reg);
    assign spi_flash_select = ~(busy && (last_grant_reg == FETCH));
    assign spi_ram_a_select = ~(busy && (last_grant_reg == MEM));
    assign spi_clk_out      = phase;
    assign spi_data_oe      = ((state_reg == CMD) || (state_reg == ADDR) ||
                               ((state_reg == DATA) && we_reg)) ? 4'hF : 4'h0;
    assign spi_data_out     = (spi_data_oe != 4'h0) ? tx_nibble : 4'h0;
    assign fetch_ack        = (state_reg == DONE) && (last_grant_reg == FETCH);
    assign mem_ack          = (state_reg == DONE) && (last_grant_reg == MEM);
    assign fetch_data       = fetch_data_reg;
    assign mem_rdata        = mem_rdata_reg;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Bench for qspi_bus_arbiter: bus-level flash/RAM device model plus a
// reference memory image; directed scenarios followed by random traffic.
module tb_qspi_bus_arbiter;

    localparam int FD = 4;
    localparam int RD = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic [7:0]  fetch_data;
    logic        fetch_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [7:0]  mem_wdata = '0;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [3:0]  spi_data_in = 4'h0;
    logic [3:0]  spi_data_out;
    logic [3:0]  spi_data_oe;
    logic        spi_clk_out;
    logic        spi_flash_select;
    logic        spi_ram_a_select;

    qspi_bus_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_req        (fetch_req),
        .fetch_addr       (fetch_addr),
        .fetch_data       (fetch_data),
        .fetch_ack        (fetch_ack),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .spi_data_in      (spi_data_in),
        .spi_data_out     (spi_data_out),
        .spi_data_oe      (spi_data_oe),
        .spi_clk_out      (spi_clk_out),
        .spi_flash_select (spi_flash_select),
        .spi_ram_a_select (spi_ram_a_select)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory images: flash_mem (read only), dev_ram (what the device holds),
    // ref_ram (what the requests say the RAM should hold).
    logic [7:0] flash_mem [0:65535];
    logic [7:0] dev_ram   [0:65535];
    logic [7:0] ref_ram   [0:65535];

    logic [3:0] nib_q[$], oe_q[$], last_nibs[$], last_oe[$];
    int cs_low_cycles = 0, last_cs_low = 0, cur_target = 0, last_target = -1;
    int both_cs_low_cnt = 0, both_ack_cnt = 0, fetch_ack_cnt = 0, mem_ack_cnt = 0;
    int mon_idx;
    logic [15:0] mon_addr;
    logic [7:0]  mon_cmd, mon_byte;

    // Bus monitor and device model, sampled mid-cycle.
    always @(negedge clock) begin
        if (!spi_flash_select && !spi_ram_a_select) both_cs_low_cnt++;
        if (fetch_ack && mem_ack) both_ack_cnt++;
        if (fetch_ack) fetch_ack_cnt++;
        if (mem_ack) mem_ack_cnt++;
        if (!spi_flash_select || !spi_ram_a_select) begin
            cur_target = spi_flash_select ? 1 : 0;
            cs_low_cycles++;
            if (spi_clk_out) begin
                nib_q.push_back(spi_data_out);
                oe_q.push_back(spi_data_oe);
                mon_idx = nib_q.size() - 1;
                mon_cmd = (nib_q.size() >= 2) ? {nib_q[0], nib_q[1]} : 8'h00;
                mon_addr = (nib_q.size() >= 8) ? {nib_q[4], nib_q[5], nib_q[6], nib_q[7]} : 16'h0;
                spi_data_in = 4'($urandom);
                if (cur_target == 0 && mon_idx >= 8 + FD && mon_idx <= 9 + FD) begin
                    mon_byte = flash_mem[mon_addr];
                    spi_data_in = (mon_idx == 8 + FD) ? mon_byte[7:4] : mon_byte[3:0];
                end
                if (cur_target == 1 && mon_cmd == 8'hEB && mon_idx >= 8 + RD && mon_idx <= 9 + RD) begin
                    mon_byte = dev_ram[mon_addr];
                    spi_data_in = (mon_idx == 8 + RD) ? mon_byte[7:4] : mon_byte[3:0];
                end
                if (cur_target == 1 && mon_cmd == 8'h38 && mon_idx == 9) begin
                    dev_ram[mon_addr] = {nib_q[8], nib_q[9]};
                end
            end
        end else if (cs_low_cycles != 0) begin
            last_nibs = nib_q;
            last_oe = oe_q;
            last_cs_low = cs_low_cycles;
            last_target = cur_target;
            nib_q.delete();
            oe_q.delete();
            cs_low_cycles = 0;
        end
    end

    logic [7:0] exp_fetch = 8'h00;
    logic [7:0] exp_mem = 8'h00;

    function automatic logic [31:0] pack_header();
        logic [31:0] h = '0;
        for (int i = 0; i < 8; i++) begin
            h = {h[27:0], (i < last_nibs.size()) ? last_nibs[i] : 4'hx};
        end
        return h;
    endfunction

    // kind: 0 = flash read, 1 = RAM read, 2 = RAM write. Called #1 after a clock edge.
    task automatic drive_req(input int kind, input logic [15:0] a, input logic [7:0] wd);
        if (kind == 0) begin
            fetch_addr = a;
            fetch_req = 1'b1;
        end else begin
            mem_addr = a;
            mem_we = (kind == 2);
            mem_wdata = wd;
            mem_req = 1'b1;
        end
    endtask

    task automatic finish_txn(input int kind, input logic [15:0] a, input logic [7:0] wd);
        int cyc, n_exp, oe_bad;
        logic [7:0] cmd;
        logic [3:0] oe_exp;
        n_exp = (kind == 0) ? 10 + FD : (kind == 1) ? 10 + RD : 10;
        cmd = (kind == 2) ? 8'h38 : 8'hEB;
        for (cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clock);
            #1;
            if ((kind == 0) ? fetch_ack : mem_ack) break;
        end
        check("latency", 64'(cyc), 64'(2 * n_exp + 1));
        fetch_req = 1'b0;
        mem_req = 1'b0;
        if (kind == 0) exp_fetch = flash_mem[a];
        if (kind == 1) exp_mem = ref_ram[a];
        if (kind == 2) ref_ram[a] = wd;
        check("fetch_data", 64'(fetch_data), 64'(exp_fetch));
        check("mem_rdata", 64'(mem_rdata), 64'(exp_mem));
        @(posedge clock);
        #1;
        check("ack_pulse_width", 64'({fetch_ack, mem_ack}), 64'(0));
        check("cs_low_cycles", 64'(last_cs_low), 64'(2 * n_exp));
        check("cs_target", 64'(last_target), 64'((kind == 0) ? 0 : 1));
        check("nibble_count", 64'(last_nibs.size()), 64'(n_exp));
        check("cmd_addr_nibbles", 64'(pack_header()), 64'({cmd, 8'h00, a}));
        oe_bad = 0;
        for (int i = 0; i < last_oe.size(); i++) begin
            oe_exp = (i < 8 || kind == 2) ? 4'hF : 4'h0;
            if (last_oe[i] !== oe_exp) oe_bad++;
        end
        check("oe_pattern", 64'(oe_bad), 64'(0));
        if (kind == 2 && last_nibs.size() >= 10) begin
            check("write_nibbles", 64'({last_nibs[8], last_nibs[9]}), 64'(wd));
        end
    endtask

    task automatic run_txn(input int kind, input logic [15:0] a, input logic [7:0] wd);
        drive_req(kind, a, wd);
        finish_txn(kind, a, wd);
    endtask

    logic [15:0] pool [0:5];
    int order[$];
    int acks0, ack_cyc, kind;
    logic [15:0] fa, ma, ra;
    logic [7:0] rb;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            flash_mem[i] = 8'($urandom);
            dev_ram[i] = 8'($urandom);
            ref_ram[i] = dev_ram[i];
        end
        flash_mem[16'h1234] = 8'hA5;
        for (int i = 0; i < 6; i++) pool[i] = 16'($urandom);

        // Reset state, checked while reset is held and after release.
        #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        check("reset_state", 64'({spi_flash_select, spi_ram_a_select, spi_clk_out, spi_data_oe, spi_data_out,
                                  fetch_ack, mem_ack, fetch_data, mem_rdata}),
              64'({1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00}));
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_after_reset", 64'({spi_flash_select, spi_ram_a_select, spi_clk_out, spi_data_oe}),
              64'({1'b1, 1'b1, 1'b0, 4'h0}));

        // Both requesters held continuously: grants must alternate F, M, F, M...
        fa = 16'($urandom);
        ma = pool[0];
        fetch_addr = fa;
        mem_addr = ma;
        mem_we = 1'b0;
        fetch_req = 1'b1;
        mem_req = 1'b1;
        for (int cyc = 0; cyc < 400 && order.size() < 6; cyc++) begin
            @(posedge clock);
            #1;
            if (fetch_ack) begin
                exp_fetch = flash_mem[fa];
                check("alt_fetch_data", 64'(fetch_data), 64'(exp_fetch));
                order.push_back(0);
                fa = 16'($urandom);
                fetch_addr = fa;
            end
            if (mem_ack) begin
                exp_mem = ref_ram[ma];
                check("alt_mem_rdata", 64'(mem_rdata), 64'(exp_mem));
                order.push_back(1);
                ma = pool[order.size() % 6];
                mem_addr = ma;
            end
        end
        fetch_req = 1'b0;
        mem_req = 1'b0;
        @(posedge clock);
        #1;
        check("alt_grant_count", 64'(order.size()), 64'(6));
        for (int i = 0; i < order.size(); i++) check("alt_grant_order", 64'(order[i]), 64'(i % 2));

        // Directed flash read, RAM write, RAM read-back.
        run_txn(0, 16'h1234, 8'h00);
        check("flash_a5", 64'(fetch_data), 64'(8'hA5));
        run_txn(2, 16'h00FF, 8'h3C);
        run_txn(1, 16'h00FF, 8'h00);
        check("ram_readback_3c", 64'(mem_rdata), 64'(8'h3C));

        // Reset in the middle of a RAM read's address phase.
        drive_req(1, pool[1], 8'h00);
        repeat (8) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("abort_outputs", 64'({spi_flash_select, spi_ram_a_select, spi_clk_out, spi_data_oe, mem_ack}),
              64'({1'b1, 1'b1, 1'b0, 4'h0, 1'b0}));
        acks0 = mem_ack_cnt;
        exp_fetch = 8'h00;
        exp_mem = 8'h00;
        @(negedge clock);
        @(negedge clock) reset = 1'b0;
        check("abort_no_ack", 64'(mem_ack_cnt - acks0), 64'(0));
        finish_txn(1, pool[1], 8'h00);
        check("abort_single_ack", 64'(mem_ack_cnt - acks0), 64'(1));

        // Fetch request withdrawn during the dummy phase still completes once.
        fa = 16'($urandom);
        drive_req(0, fa, 8'h00);
        acks0 = fetch_ack_cnt;
        ack_cyc = 0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clock);
            #1;
            if (cyc == 21) fetch_req = 1'b0;
            if (fetch_ack && ack_cyc == 0) ack_cyc = cyc;
        end
        exp_fetch = flash_mem[fa];
        check("drop_ack_count", 64'(fetch_ack_cnt - acks0), 64'(1));
        check("drop_ack_cycle", 64'(ack_cyc), 64'(29));
        check("drop_fetch_data", 64'(fetch_data), 64'(exp_fetch));
        check("drop_bus_idle", 64'({spi_flash_select, spi_ram_a_select, spi_clk_out}), 64'({1'b1, 1'b1, 1'b0}));

        // Random traffic over a small address pool so writes get read back.
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 2);
            ra = (kind == 0) ? 16'($urandom) : pool[$urandom_range(0, 5)];
            rb = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock);
                #1;
            end
            run_txn(kind, ra, rb);
        end

        check("never_two_cs_low", 64'(both_cs_low_cnt), 64'(0));
        check("never_two_acks", 64'(both_ack_cnt), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qspi_bus_arbiter.md
Name: qspi_bus_arbiter

Overview:
Shares the single quad-SPI bus between the CPU instruction-fetch port (serial flash) and the CPU data port (serial RAM A). It arbitrates round-robin and sequences one byte transaction per grant: command, address, dummy and data nibbles in QPI mode. It drives the chip selects, SPI clock and per-line output enables. It sits inside cpu, between the fetch/memory stages and the top-level uio pins.

Parameters:
ADDRESS_WIDTH, 16, CPU address width; zero-extended to the 24-bit SPI address.
DATA_BUS_WIDTH, 8, transfer width; fixed at 8 (2 nibbles).
FLASH_DUMMY, 4, dummy SPI clocks for a flash read.
RAM_DUMMY, 6, dummy SPI clocks for a RAM read.
CMD_FLASH_READ, 8'hEB, flash quad read opcode.
CMD_RAM_READ, 8'hEB, RAM quad read opcode.
CMD_RAM_WRITE, 8'h38, RAM quad write opcode.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
fetch_req  in  1  fetch request; level, held until fetch_ack
fetch_addr  in  ADDRESS_WIDTH  flash byte address
fetch_data  out  8  flash read data; valid with fetch_ack, held until next fetch ack
fetch_ack  out  1  one-cycle completion pulse
mem_req  in  1  data request; level, held until mem_ack
mem_we  in  1  1 = RAM write, 0 = RAM read
mem_addr  in  ADDRESS_WIDTH  RAM byte address
mem_wdata  in  8  write data
mem_rdata  out  8  RAM read data; valid with mem_ack
mem_ack  out  1  one-cycle completion pulse
spi_data_in  in  4  IO[3:0] from pads
spi_data_out  out  4  IO[3:0] to pads
spi_data_oe  out  4  per-line output enable, 1 = drive
spi_clk_out  out  1  SPI clock, idle low
spi_flash_select  out  1  flash CS, active low
spi_ram_a_select  out  1  RAM A CS, active low

Behaviour:
- Reset state (async, immediate): both selects=1, spi_clk_out=0, spi_data_oe=0, spi_data_out=0, both acks=0, fetch_data=mem_rdata=0, state=IDLE, last_grant=MEM.
- A reset asserted mid-transaction aborts it. CS deasserts in the same instant and no ack is issued.
- Nibble timing: each nibble takes 2 clock cycles.
  - Phase 0: spi_clk_out=0; out/oe update.
  - Phase 1: spi_clk_out=1.
  - spi_data_in is sampled on the edge that ends phase 1.
- Nibble order is MSB first throughout.
- Arbitration in IDLE:
  - Only one requester active: grant it.
  - Both active: grant the one not equal to last_grant, then update last_grant.
  - At the grant edge, latch address, we and wdata; drive the target CS low from the next cycle.
- States:
  - IDLE.
  - CMD: 2 nibbles, oe=4'hF.
  - ADDR: 6 nibbles, {zero-ext, addr}, oe=4'hF.
  - DUMMY: N SPI clocks, oe=0. Flash N=FLASH_DUMMY; RAM read N=RAM_DUMMY; write skips DUMMY.
  - DATA: 2 nibbles. Read: oe=0, shift in. Write: oe=4'hF, wdata out.
  - DONE: 1 cycle. CS=1, clk=0, oe=0. The matching ack pulses. Then IDLE.
- Latency from grant edge to ack cycle is 2*(10+N)+1 clocks:
  - flash read: 29
  - RAM read: 33
  - RAM write: 21
- A new grant is possible on the cycle after DONE, so CS is high for at least 2 cycles between transactions.
- A requester that drops req mid-transaction does not cancel it; the transaction completes and ack still pulses.
- A req held high after ack is treated as a new request.
- At most one CS is low at any time. Both acks are never high together.
- Reads return the byte on rdata with ack. rdata is unchanged by transactions on the other port.

Decomposition:
- Package qspi_pkg holds:
  - state enum {IDLE, CMD, ADDR, DUMMY, DATA, DONE}
  - grant enum {FETCH, MEM}
  - opcode localparams
  - nibble count constants (CMD_NIBBLES=2, ADDR_NIBBLES=6, DATA_NIBBLES=2)
- One sub-module, qspi_nibble_shifter:
  - 32-bit load/shift-out register plus 8-bit shift-in register
  - phase toggle generating spi_clk_out
  - the FSM counts nibbles via its strobe.

Test Plan:
- fetch_req=1, fetch_addr=16'h1234, flash model byte 8'hA5 → CS_flash low for 28 cycles; out nibbles EB,00,12,34; fetch_ack at cycle 29 with fetch_data=8'hA5.
- mem_req=1, mem_we=1, addr=16'h00FF, wdata=8'h3C → RAM model sees 38,00,00,FF,3C with no dummy; mem_ack at cycle 21; oe=4'hF during the whole CS-low window.
- mem read addr 16'h00FF after that write → oe=0 during DUMMY/DATA; mem_rdata=8'h3C at cycle 33.
- Both requests asserted the same cycle after reset → fetch granted first, mem next. Repeat with both held continuously → grants alternate F, M, F, M; never two CS low.
- Reset pulsed during ADDR of a RAM read → selects=1, clk=0, oe=0 immediately; no mem_ack. After release, the held mem_req restarts cleanly from CMD.
- fetch_req dropped in DUMMY → transaction finishes and fetch_ack still pulses once; bus then returns to IDLE.
